adc_sample_sched: RTL

Sample scheduler between the dual-channel ADC front end and the two consumers, the PID loop and the CORDIC unit. A programmable period timer triggers a two-conversion sequence (channel 0, then channel 1) over a start/done handshake with the ADC. The captured pair is then delivered over independent valid/ready handshakes: channel 0 to the PID, the {ch0, ch1} pair to the CORDIC. It also flags sequence overruns and ADC timeouts.

---
 rtl/adc_sched_pkg.sv | 21 ++
 rtl/adc_sample_sched_period_timer.sv | 36 +++
 rtl/adc_sample_sched.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and defaults for the ADC sample scheduler.
package adc_sched_pkg;

    localparam int DW_DEFAULT      = 12;
    localparam int OVR_W           = 8;
    localparam int TIMEOUT_DEFAULT = 255;

    // Sequence controller states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONV0    = 2'd1,
        ST_CONV1    = 2'd2,
        ST_DISPATCH = 2'd3
    } state_t;

    // Saturating increment for the overrun counter.
    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == '1) ? v : v + OVR_W'(1);
    endfunction

endpackage

// File: rtl/adc_sample_sched_period_timer.sv
// Programmable period timer: one tick every max(period,1) cycles while en is high.
module period_timer #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [PW-1:0] period,
    output logic          tick
);

    logic [PW-1:0] cnt_reg;
    logic [PW-1:0] cnt_next;
    logic [PW-1:0] last_cnt;

    // Tick when the count has reached the last slot of the (clamped) period;
    // comparing with >= lets a shortened period take effect immediately.
    always_comb begin
        last_cnt = (period == '0) ? '0 : period - PW'(1);
        tick     = en && (cnt_reg >= last_cnt);
        cnt_next = cnt_reg + PW'(1);
        if (!en || tick) begin
            cnt_next = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/adc_sample_sched.sv
// ADC sample scheduler: timer-triggered ch0/ch1 conversion pair, delivered to
// the PID (ch0) and the CORDIC ({ch0, ch1}) over independent valid/ready links.
module adc_sample_sched
    import adc_sched_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int PW      = 16,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [PW-1:0]    period,
    input  logic             err_clr,
    output logic             adc_start,
    output logic             adc_ch,
    input  logic             adc_done,
    input  logic [DW-1:0]    adc_data,
    output logic [DW-1:0]    pid_data,
    output logic             pid_valid,
    input  logic             pid_ready,
    output logic [DW-1:0]    cordic_x,
    output logic [DW-1:0]    cordic_y,
    output logic             cordic_valid,
    input  logic             cordic_ready,
    output logic             busy,
    output logic             err_timeout,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    logic             tick;

    state_t           state_reg, state_next;
    logic             start_reg, start_next;
    logic             ch_reg, ch_next;
    logic [WDW-1:0]   wd_reg, wd_next;
    logic [DW-1:0]    cap0_reg, cap0_next;
    logic [DW-1:0]    x_reg, x_next;
    logic [DW-1:0]    y_reg, y_next;
    logic             busy_reg;
    logic             err_reg, err_next;
    logic [OVR_W-1:0] ovr_reg, ovr_next;

    logic             done_ok;
    logic             timeout_evt;
    logic             overrun_evt;
    logic             load_out;
    logic [1:0]       valid_q;
    logic [1:0]       rdy;
    logic [1:0]       slot_free;

    period_timer #(.PW(PW)) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .period (period),
        .tick   (tick)
    );

    // Slot 0 feeds the PID, slot 1 the CORDIC; each keeps its own valid.
    assign rdy = {cordic_ready, pid_ready};

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic valid_reg;
        logic valid_next;

        assign valid_next     = load_out | (valid_reg & ~rdy[gi]);
        assign valid_q[gi]    = valid_reg;
        assign slot_free[gi]  = ~valid_reg | rdy[gi];

        // Valid rises on dispatch entry and drops after its own accept.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                valid_reg <= 1'b0;
            end else begin
                valid_reg <= valid_next;
            end
        end
    end

    // adc_done is meaningful only after the start cycle of a conversion.
    assign done_ok     = adc_done && !start_reg;
    assign overrun_evt = tick && (state_reg != ST_IDLE);

    // Sequence control, watchdog and capture.
    always_comb begin
        state_next  = state_reg;
        start_next  = 1'b0;
        ch_next     = ch_reg;
        wd_next     = wd_reg;
        cap0_next   = cap0_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        timeout_evt = 1'b0;
        load_out    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (tick) begin
                    state_next = ST_CONV0;
                    start_next = 1'b1;
                    ch_next    = 1'b0;
                    wd_next    = '0;
                end
            end
            ST_CONV0: begin
                if (done_ok) begin
                    cap0_next  = adc_data;
                    state_next = ST_CONV1;
                    start_next = 1'b1;
                    ch_next    = 1'b1;
                    wd_next    = '0;
                end else if (wd_reg == WD_LAST) begin
                    timeout_evt = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    wd_next = wd_reg + WDW'(1);
                end
            end
            ST_CONV1: begin
                if (done_ok) begin
                    // Outputs load only when the pair is complete, so an
                    // aborted sequence never disturbs delivered data.
                    x_next     = cap0_reg;
                    y_next     = adc_data;
                    load_out   = 1'b1;
                    state_next = ST_DISPATCH;
                end else if (wd_reg == WD_LAST) begin
                    timeout_evt = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    wd_next = wd_reg + WDW'(1);
                end
            end
            ST_DISPATCH: begin
                if (&slot_free) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sticky error and overrun counter; a new event beats a same-cycle clear.
    always_comb begin
        err_next = err_reg;
        ovr_next = ovr_reg;
        if (timeout_evt) begin
            err_next = 1'b1;
        end else if (err_clr) begin
            err_next = 1'b0;
        end
        if (overrun_evt) begin
            ovr_next = sat_inc(ovr_reg);
        end else if (err_clr) begin
            ovr_next = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            start_reg <= 1'b0;
            ch_reg    <= 1'b0;
            wd_reg    <= '0;
            cap0_reg  <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b0;
            ovr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            start_reg <= start_next;
            ch_reg    <= ch_next;
            wd_reg    <= wd_next;
            cap0_reg  <= cap0_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            busy_reg  <= (state_next != ST_IDLE);
            err_reg   <= err_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign adc_start    = start_reg;
    assign adc_ch       = ch_reg;
    assign pid_data     = x_reg;
    assign pid_valid    = valid_q[0];
    assign cordic_x     = x_reg;
    assign cordic_y     = y_reg;
    assign cordic_valid = valid_q[1];
    assign busy         = busy_reg;
    assign err_timeout  = err_reg;
    assign overrun_cnt  = ovr_reg;

endmodule
